// File: rtl/neopx_bit_tx.sv
// WS2812 bitstream driver: takes one pixel word per valid/ready handshake and
// serialises bits [23:0] MSB-first with cycle-counted high/low pulse widths,
// then holds the line low for the latch period and pulses o_frame_done.
module neopx_bit_tx #(
  parameter int T0H_CYC   = 29,
  parameter int T0L_CYC   = 61,
  parameter int T1H_CYC   = 58,
  parameter int T1L_CYC   = 32,
  parameter int LATCH_CYC = 4320,
  parameter int CNT_W     = 13
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] s_axis_data,
  input  logic        s_axis_valid,
  output logic        s_axis_ready,
  output logic        o_neopx,
  output logic        o_busy,
  output logic        o_frame_done
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

  // Terminal counts are "length - 1" because every counter starts at 0 on
  // state entry.
  localparam logic [CNT_W-1:0] T0H_END   = CNT_W'(T0H_CYC - 1);
  localparam logic [CNT_W-1:0] T0L_END   = CNT_W'(T0L_CYC - 1);
  localparam logic [CNT_W-1:0] T1H_END   = CNT_W'(T1H_CYC - 1);
  localparam logic [CNT_W-1:0] T1L_END   = CNT_W'(T1L_CYC - 1);
  localparam logic [CNT_W-1:0] LATCH_END = CNT_W'(LATCH_CYC - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [4:0]       bit_cnt, bit_cnt_n;
  logic [23:0]      shift, shift_n;
  logic             line, line_n;
  logic             done, done_n;
  logic             accept;
  logic [CNT_W-1:0] hi_end, lo_end;

  // Ready depends on state only; held low while reset is asserted.
  assign s_axis_ready = ((state == IDLE) || (state == GAP)) && !i_rst;
  assign accept       = s_axis_ready && s_axis_valid;
  assign o_neopx      = line;
  assign o_busy       = (state != IDLE);
  assign o_frame_done = done;

  // Pulse widths are chosen from the shift register MSB only.
  assign hi_end = shift[23] ? T1H_END : T0H_END;
  assign lo_end = shift[23] ? T1L_END : T0L_END;

  // Next-state and datapath update.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (accept) begin
          shift_n   = s_axis_data[23:0];
          bit_cnt_n = '0;
          state_n   = HIGH;
        end
      end
      HIGH: begin
        if (cnt == hi_end) begin
          cnt_n   = '0;
          state_n = LOW;
        end
      end
      LOW: begin
        if (cnt == lo_end) begin
          cnt_n = '0;
          if (bit_cnt == 5'd23) begin
            state_n = GAP;
          end else begin
            shift_n   = {shift[22:0], 1'b0};
            bit_cnt_n = bit_cnt + 5'd1;
            state_n   = HIGH;
          end
        end
      end
      GAP: begin
        // A pixel arriving anywhere in the gap, including its last cycle,
        // continues the frame and suppresses the latch.
        if (accept) begin
          shift_n   = s_axis_data[23:0];
          bit_cnt_n = '0;
          cnt_n     = '0;
          state_n   = HIGH;
        end else if (cnt == LATCH_END) begin
          cnt_n   = '0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
    line_n = (state_n == HIGH);
  end

  // State and datapath registers; reset forces the line low at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      line    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      line    <= line_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_neopx_bit_tx.sv
// Self-checking bench: a line monitor decodes WS2812 pulses into words and
// compares them with a queue of accepted pixels; tasks check handshake,
// latency, latch timing and reset behaviour.
module tb_neopx_bit_tx;
  localparam int T0H = 29, T0L = 61, T1H = 58, T1L = 32, LATCH = 4320;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic        valid = 1'b0;
  logic        ready, neopx, busy, fdone;

  always #5 clk = ~clk;

  neopx_bit_tx dut (
    .i_clk(clk), .i_rst(rst), .s_axis_data(data), .s_axis_valid(valid),
    .s_axis_ready(ready), .o_neopx(neopx), .o_busy(busy), .o_frame_done(fdone)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          fd_cnt   = 0;
  logic [23:0] exp_q[$];

  // line monitor state
  int          hi_run = 0, lo_run = 0, nbits = 0;
  bit          first = 1'b1, prev = 1'b0, last_bit = 1'b0, prev_fd = 1'b0;
  logic [23:0] sh = '0;

  // Decode the serial line: high width gives the bit, low width must match it.
  always @(negedge clk) begin
    if (rst) begin
      hi_run = 0; lo_run = 0; nbits = 0; first = 1'b1; prev = 1'b0; prev_fd = 1'b0;
    end else begin
      if (fdone) begin
        n_checks++;
        if (lo_run != (last_bit ? T1L : T0L) + LATCH || prev_fd || nbits != 0) begin
          n_fail++;
          $display("FAIL frame_done_timing: low run %0d prev_pulse %0d nbits %0d, required low %0d prev_pulse 0 nbits 0",
                   lo_run, prev_fd, nbits, (last_bit ? T1L : T0L) + LATCH);
        end
        fd_cnt++;
        first = 1'b1;
      end
      prev_fd = fdone;
      if (neopx) begin
        if (!prev) begin
          if (!first) begin
            n_checks++;
            if (nbits != 0) begin
              if (lo_run != (last_bit ? T1L : T0L)) begin
                n_fail++;
                $display("FAIL low_width: got %0d, required %0d (bit %0d)", lo_run, last_bit ? T1L : T0L, last_bit);
              end
            end else if (lo_run < T1L + 1) begin
              n_fail++;
              $display("FAIL gap_low_width: got %0d, required >= %0d", lo_run, T1L + 1);
            end
          end
          first  = 1'b0;
          hi_run = 0;
        end
        hi_run++;
      end else begin
        if (prev) begin
          n_checks++;
          if (hi_run == T1H) last_bit = 1'b1;
          else if (hi_run == T0H) last_bit = 1'b0;
          else begin
            last_bit = 1'b0;
            n_fail++;
            $display("FAIL high_width: got %0d, required %0d or %0d", hi_run, T0H, T1H);
          end
          sh = {sh[22:0], last_bit};
          nbits++;
          if (nbits == 24) begin
            nbits = 0;
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL word_unexpected: got %06h, required none", sh);
            end else begin
              logic [23:0] e;
              e = exp_q.pop_front();
              if (sh !== e) begin
                n_fail++;
                $display("FAIL word_data: got %06h, required %06h", sh, e);
              end
            end
          end
          lo_run = 0;
        end
        lo_run++;
      end
      prev = neopx;
    end
  end

  task automatic wait_ready(output int t);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ready && t < 10000);
    if (!ready) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: got ready 0 after %0d cycles, required 1", t);
    end
  endtask

  task automatic send(input logic [31:0] w, input int lag);
    int t;
    wait_ready(t);
    repeat (lag) @(negedge clk);
    data = w; valid = 1'b1;
    exp_q.push_back(w[23:0]);
    @(posedge clk); #1;
    valid = 1'b0; data = $urandom;
    n_checks++;
    if (neopx !== 1'b1 || ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_latency: got line %b ready %b busy %b, required 1 0 1", neopx, ready, busy);
    end
  endtask

  task automatic wait_done(input int budget);
    int f0, t;
    f0 = fd_cnt; t = 0;
    while (fd_cnt == f0 && t < budget) begin @(negedge clk); t++; end
    #1;
    n_checks++;
    if (fd_cnt == f0) begin
      n_fail++;
      $display("FAIL frame_done_timeout: got no pulse in %0d cycles, required one", budget);
    end
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL idle_after_frame: got ready %b busy %b pending %0d, required 1 0 0", ready, busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_checks++;
    if (neopx !== 1'b0 || busy !== 1'b0 || fdone !== 1'b0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got line %b busy %b done %b ready %b, required 0 0 0 0", neopx, busy, fdone, ready);
    end
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || neopx !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready %b busy %b line %b, required 1 0 0", ready, busy, neopx);
    end
  endtask

  task automatic test_single();
    int t;
    send(32'h0080_0001, 0);
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy: got ready %b busy %b, required 0 1", ready, busy);
    end
    t = 1;
    while (!ready && t < 3000) begin @(negedge clk); t++; end
    n_checks++;
    if (t != 24 * 90 + 1) begin
      n_fail++;
      $display("FAIL gap_entry: got cycle %0d, required %0d", t, 24 * 90 + 1);
    end
    for (int i = 0; i < 4; i++) begin
      repeat (1000) @(negedge clk);
      n_checks++;
      if (ready !== 1'b1 || busy !== 1'b1 || neopx !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_state: got ready %b busy %b line %b, required 1 1 0", ready, busy, neopx);
      end
    end
    wait_done(500);
  endtask

  task automatic test_back_to_back();
    int t, f0;
    f0 = fd_cnt;
    send(32'hFF00_FF00, 0);
    wait_ready(t);
    repeat (9) @(negedge clk);
    send(32'h0000_00FF, 0);
    n_checks++;
    if (fd_cnt != f0) begin
      n_fail++;
      $display("FAIL b2b_no_latch: got %0d frame_done, required 0", fd_cnt - f0);
    end
    wait_done(8000);
    n_checks++;
    if (fd_cnt - f0 != 1) begin
      n_fail++;
      $display("FAIL b2b_done_count: got %0d, required 1", fd_cnt - f0);
    end
  endtask

  task automatic test_ignore_busy();
    send(32'h0012_3456, 0);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      data  = 32'h00FF_FFFF;
      valid = (i % 7 == 0);
      n_checks++;
      if (ready !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_ready: got %b at cycle %0d, required 0", ready, i);
      end
    end
    @(negedge clk);
    valid = 1'b0;
    wait_done(8000);
  endtask

  task automatic test_final_gap();
    int t, f0;
    f0 = fd_cnt;
    send(32'h00A5_0F3C, 0);
    wait_ready(t);
    repeat (LATCH - 1) @(negedge clk);
    data = 32'h00C3_7E01; valid = 1'b1;
    exp_q.push_back(24'hC37E01);
    @(posedge clk); #1;
    valid = 1'b0;
    n_checks++;
    if (neopx !== 1'b1 || fdone !== 1'b0 || fd_cnt != f0) begin
      n_fail++;
      $display("FAIL final_gap_accept: got line %b done %b pulses %0d, required 1 0 0", neopx, fdone, fd_cnt - f0);
    end
    wait_done(8000);
    n_checks++;
    if (fd_cnt - f0 != 1) begin
      n_fail++;
      $display("FAIL final_gap_done_count: got %0d, required 1", fd_cnt - f0);
    end
  endtask

  task automatic test_reset_mid();
    send(32'h00FF_FFFF, 0);
    repeat (5 * 90 + 20) @(posedge clk);
    #2;
    n_checks++;
    if (neopx !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_high_line: got %b, required 1", neopx);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (neopx !== 1'b0 || ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got line %b ready %b busy %b, required 0 0 0", neopx, ready, busy);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_recover: got ready %b busy %b, required 1 0", ready, busy);
    end
    send(32'h005A_5AC3, 0);
    wait_done(8000);
  endtask

  task automatic test_random_frame();
    int f0;
    f0 = fd_cnt;
    for (int i = 0; i < 8; i++) send($urandom, 1);
    wait_done(8000);
    n_checks++;
    if (fd_cnt - f0 != 1) begin
      n_fail++;
      $display("FAIL random_done_count: got %0d, required 1", fd_cnt - f0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_final_gap();
    test_reset_mid();
    test_random_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
